// File: rtl/sequence_scorer.sv
// rtl/sequence_scorer.sv - piano sequence round scorer: press capture, miss tracking, lives and level
module sequence_scorer #(
  parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       hard_reset,
  input  logic       auto_reset,
  input  logic       level_one_active,
  input  logic       check_score_enable,
  input  logic       next_level,
  input  logic [5:0] user_input,
  output logic       ih_isdone,
  output logic       win,
  output logic [1:0] lives,
  output logic [1:0] level,
  output logic [5:0] expected_note,
  output logic [2:0] note_index
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       note_index_q, note_index_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             miss_q, miss_d;
  logic             ih_isdone_q, ih_isdone_d;
  logic             win_q, win_d;
  logic [1:0]       lives_q, lives_d;
  logic [1:0]       level_q, level_d;
  logic [5:0]       sample_q, sample_d;

  logic press;
  logic timeout;
  logic last_note;

  // Look up the one-hot note expected at the current position; past the end of the sequence nothing is expected.
  always_comb begin
    expected_note = 6'b000000;
    case ({level_q, note_index_q})
      5'b00_000: expected_note = 6'b000001;
      5'b00_001: expected_note = 6'b000100;
      5'b00_010: expected_note = 6'b010000;
      5'b01_000: expected_note = 6'b000010;
      5'b01_001: expected_note = 6'b001000;
      5'b01_010: expected_note = 6'b100000;
      5'b01_011: expected_note = 6'b001000;
      5'b10_000: expected_note = 6'b100000;
      5'b10_001: expected_note = 6'b010000;
      5'b10_010: expected_note = 6'b000100;
      5'b10_011: expected_note = 6'b000001;
      5'b10_100: expected_note = 6'b000010;
      5'b11_000: expected_note = 6'b000100;
      5'b11_001: expected_note = 6'b000001;
      5'b11_010: expected_note = 6'b001000;
      5'b11_011: expected_note = 6'b100000;
      5'b11_100: expected_note = 6'b000010;
      5'b11_101: expected_note = 6'b010000;
      default:   expected_note = 6'b000000;
    endcase
  end

  // Next-state and datapath updates, resolved in control priority order.
  always_comb begin
    state_d      = state_q;
    note_index_d = note_index_q;
    idle_cnt_d   = idle_cnt_q;
    miss_d       = miss_q;
    ih_isdone_d  = ih_isdone_q;
    win_d        = win_q;
    lives_d      = lives_q;
    level_d      = level_q;
    sample_d     = sample_q;

    // A press is a rising edge of "any key down" seen only while capturing.
    press     = (state_q == ARMED) && (user_input != 6'd0) && (sample_q == 6'd0);
    timeout   = (idle_cnt_q == CNT_LAST);
    last_note = (note_index_q == ({1'b0, level_q} + 3'd2));

    if (state_q == ARMED) begin
      sample_d = user_input;
    end

    if (hard_reset) begin
      state_d      = IDLE;
      note_index_d = 3'd0;
      idle_cnt_d   = '0;
      miss_d       = 1'b0;
      ih_isdone_d  = 1'b0;
      win_d        = 1'b0;
      lives_d      = 2'd3;
      level_d      = 2'd0;
      sample_d     = 6'd0;
    end else if (auto_reset || next_level) begin
      // Both round-level clears share the return to IDLE; next_level additionally advances.
      state_d      = IDLE;
      note_index_d = 3'd0;
      idle_cnt_d   = '0;
      miss_d       = 1'b0;
      ih_isdone_d  = 1'b0;
      win_d        = 1'b0;
      sample_d     = 6'd0;
      if (next_level) begin
        lives_d = 2'd3;
        if (level_q != 2'd3) begin
          level_d = level_q + 2'd1;
        end
      end
    end else if (check_score_enable && (state_q == DONE)) begin
      win_d = ~miss_q;
      if (miss_q && (lives_q != 2'd0)) begin
        lives_d = lives_q - 2'd1;
      end
    end else if (level_one_active && (state_q == IDLE)) begin
      state_d = ARMED;
    end else if (state_q == ARMED) begin
      if (press) begin
        // Any mismatch, including chords, counts as a miss.
        if (user_input != expected_note) begin
          miss_d = 1'b1;
        end
        note_index_d = note_index_q + 3'd1;
        idle_cnt_d   = '0;
        if (last_note) begin
          state_d     = DONE;
          ih_isdone_d = 1'b1;
        end
      end else if (timeout) begin
        miss_d      = 1'b1;
        state_d     = DONE;
        ih_isdone_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + CNT_W'(1);
      end
    end
  end

  // State and datapath registers with asynchronous power-on clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      note_index_q <= 3'd0;
      idle_cnt_q   <= '0;
      miss_q       <= 1'b0;
      ih_isdone_q  <= 1'b0;
      win_q        <= 1'b0;
      lives_q      <= 2'd3;
      level_q      <= 2'd0;
      sample_q     <= 6'd0;
    end else begin
      state_q      <= state_d;
      note_index_q <= note_index_d;
      idle_cnt_q   <= idle_cnt_d;
      miss_q       <= miss_d;
      ih_isdone_q  <= ih_isdone_d;
      win_q        <= win_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      sample_q     <= sample_d;
    end
  end

  assign ih_isdone  = ih_isdone_q;
  assign win        = win_q;
  assign lives      = lives_q;
  assign level      = level_q;
  assign note_index = note_index_q;

endmodule

// File: tb/tb_sequence_scorer.sv
// tb/tb_sequence_scorer.sv - self-checking bench for sequence_scorer
module tb_sequence_scorer;

  logic       clock;
  logic       resetn;
  logic       hard_reset;
  logic       auto_reset;
  logic       level_one_active;
  logic       check_score_enable;
  logic       next_level;
  logic [5:0] user_input;
  logic       ih_isdone;
  logic       win;
  logic [1:0] lives;
  logic [1:0] level;
  logic [5:0] expected_note;
  logic [2:0] note_index;

  int n_checks = 0;
  int n_errors = 0;

  int seq_tab [4][6] = '{'{0, 2, 4, 0, 0, 0},
                         '{1, 3, 5, 3, 0, 0},
                         '{5, 4, 2, 0, 1, 0},
                         '{2, 0, 3, 5, 1, 4}};

  sequence_scorer #(.TIMEOUT_CYCLES(20)) dut (
    .clock              (clock),
    .resetn             (resetn),
    .hard_reset         (hard_reset),
    .auto_reset         (auto_reset),
    .level_one_active   (level_one_active),
    .check_score_enable (check_score_enable),
    .next_level         (next_level),
    .user_input         (user_input),
    .ih_isdone          (ih_isdone),
    .win                (win),
    .lives              (lives),
    .level              (level),
    .expected_note      (expected_note),
    .note_index         (note_index)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       hr, ar, l1, ck, nl;
    logic [5:0] ui;
    logic       done, win;
    logic [1:0] lives, level;
    logic [2:0] idx;
    logic [5:0] exp;
  } vec_t;

  function automatic vec_t mk(int hr, int ar, int l1, int ck, int nl, int ui,
                              int done, int w, int lv, int lev, int idx, int ex);
    vec_t v;
    v.hr = hr[0]; v.ar = ar[0]; v.l1 = l1[0]; v.ck = ck[0]; v.nl = nl[0];
    v.ui = ui[5:0]; v.done = done[0]; v.win = w[0]; v.lives = lv[1:0];
    v.level = lev[1:0]; v.idx = idx[2:0]; v.exp = ex[5:0];
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic hr, input logic ar, input logic l1, input logic ck,
                      input logic nl, input logic [5:0] ui);
    @(negedge clock);
    hard_reset = hr; auto_reset = ar; level_one_active = l1;
    check_score_enable = ck; next_level = nl; user_input = ui;
    @(posedge clock);
    #1;
  endtask

  // Arm and play a whole round at level lvl; wrong_pos selects one deliberately wrong note (-1 for none).
  task automatic play(input int lvl, input int wrong_pos);
    logic [5:0] v;
    step(0, 0, 1, 0, 0, 6'd0);
    for (int i = 0; i < lvl + 3; i++) begin
      v = 6'd1 << seq_tab[lvl][i];
      if (i == wrong_pos) v = 6'd1 << ((seq_tab[lvl][i] + 1) % 6);
      step(0, 0, 0, 0, 0, v);
      chk("play_done_flag", int'(ih_isdone), (i == lvl + 2) ? 1 : 0);
      step(0, 0, 0, 0, 0, 6'd0);
    end
  endtask

  // Reference model: round rules expressed over plain integers and the note table.
  int         m_state;  // 0 idle, 1 capturing, 2 finished
  int         m_idx, m_idle, m_lives, m_level;
  bit         m_miss, m_done, m_win;
  logic [5:0] m_prev;

  function automatic logic [5:0] m_expected();
    if (m_idx < m_level + 3) return 6'd1 << seq_tab[m_level][m_idx];
    return 6'd0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_idx = 0; m_idle = 0; m_lives = 3; m_level = 0;
    m_miss = 0; m_done = 0; m_win = 0; m_prev = 6'd0;
  endtask

  task automatic model_step(input bit hr, input bit ar, input bit l1, input bit ck,
                            input bit nl, input logic [5:0] ui);
    logic [5:0] nprev;
    bit         pressed;
    pressed = (m_state == 1) && (ui != 0) && (m_prev == 0);
    nprev   = (m_state == 1) ? ui : m_prev;
    if (hr) begin
      model_reset();
      nprev = 6'd0;
    end else if (ar || nl) begin
      m_state = 0; m_idx = 0; m_idle = 0; m_miss = 0; m_done = 0; m_win = 0;
      nprev = 6'd0;
      if (nl) begin
        m_lives = 3;
        m_level = (m_level < 3) ? m_level + 1 : 3;
      end
    end else if (ck && m_state == 2) begin
      m_win = !m_miss;
      if (m_miss && m_lives > 0) m_lives = m_lives - 1;
    end else if (l1 && m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (pressed) begin
        if (ui != m_expected()) m_miss = 1;
        if (m_idx == m_level + 2) begin
          m_state = 2; m_done = 1;
        end
        m_idx = m_idx + 1;
        m_idle = 0;
      end else if (m_idle == 19) begin
        m_miss = 1; m_state = 2; m_done = 1;
      end else begin
        m_idle = m_idle + 1;
      end
    end
    m_prev = nprev;
  endtask

  vec_t       tbl[17];
  bit         r_hr, r_ar, r_l1, r_ck, r_nl;
  logic [5:0] r_ui;
  int         r;

  initial begin
    resetn = 1'b0;
    hard_reset = 0; auto_reset = 0; level_one_active = 0;
    check_score_enable = 0; next_level = 0; user_input = 6'd0;

    //               hr ar l1 ck nl ui    done win lives lvl idx exp
    tbl[0]  = mk(0, 0, 1, 0, 0, 'h00,  0, 0, 3, 0, 0, 'h01);
    tbl[1]  = mk(0, 0, 0, 0, 0, 'h01,  0, 0, 3, 0, 1, 'h04);
    tbl[2]  = mk(0, 0, 0, 0, 0, 'h00,  0, 0, 3, 0, 1, 'h04);
    tbl[3]  = mk(0, 0, 0, 0, 0, 'h04,  0, 0, 3, 0, 2, 'h10);
    tbl[4]  = mk(0, 0, 0, 0, 0, 'h00,  0, 0, 3, 0, 2, 'h10);
    tbl[5]  = mk(0, 0, 0, 0, 0, 'h10,  1, 0, 3, 0, 3, 'h00);
    tbl[6]  = mk(0, 0, 0, 1, 0, 'h00,  1, 1, 3, 0, 3, 'h00);
    tbl[7]  = mk(0, 1, 0, 0, 0, 'h00,  0, 0, 3, 0, 0, 'h01);
    tbl[8]  = mk(0, 0, 1, 0, 0, 'h00,  0, 0, 3, 0, 0, 'h01);
    tbl[9]  = mk(0, 0, 0, 0, 0, 'h01,  0, 0, 3, 0, 1, 'h04);
    tbl[10] = mk(0, 0, 0, 0, 0, 'h00,  0, 0, 3, 0, 1, 'h04);
    tbl[11] = mk(0, 0, 0, 0, 0, 'h08,  0, 0, 3, 0, 2, 'h10);
    tbl[12] = mk(0, 0, 0, 0, 0, 'h00,  0, 0, 3, 0, 2, 'h10);
    tbl[13] = mk(0, 0, 0, 0, 0, 'h10,  1, 0, 3, 0, 3, 'h00);
    tbl[14] = mk(0, 0, 0, 1, 0, 'h00,  1, 0, 2, 0, 3, 'h00);
    tbl[15] = mk(0, 1, 0, 0, 0, 'h00,  0, 0, 2, 0, 0, 'h01);
    tbl[16] = mk(0, 0, 0, 1, 0, 'h00,  0, 0, 2, 0, 0, 'h01);

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_done", int'(ih_isdone), 0);
    chk("rst_win", int'(win), 0);
    chk("rst_lives", int'(lives), 3);
    chk("rst_level", int'(level), 0);
    chk("rst_idx", int'(note_index), 0);
    chk("rst_exp", int'(expected_note), 1);
    @(negedge clock);
    resetn = 1'b1;

    // Table: a winning then a losing level-0 round
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].hr, tbl[i].ar, tbl[i].l1, tbl[i].ck, tbl[i].nl, tbl[i].ui);
      chk($sformatf("tbl%0d_done", i), int'(ih_isdone), int'(tbl[i].done));
      chk($sformatf("tbl%0d_win", i), int'(win), int'(tbl[i].win));
      chk($sformatf("tbl%0d_lives", i), int'(lives), int'(tbl[i].lives));
      chk($sformatf("tbl%0d_level", i), int'(level), int'(tbl[i].level));
      chk($sformatf("tbl%0d_idx", i), int'(note_index), int'(tbl[i].idx));
      if (int'(tbl[i].idx) < int'(tbl[i].level) + 3)
        chk($sformatf("tbl%0d_exp", i), int'(expected_note), int'(tbl[i].exp));
    end

    // Lives saturate at zero over repeated losses
    for (int k = 0; k < 3; k++) begin
      play(0, 1);
      step(0, 0, 0, 1, 0, 6'd0);
      chk("sat_win", int'(win), 0);
      chk("sat_lives", int'(lives), (k == 0) ? 1 : 0);
      step(0, 1, 0, 0, 0, 6'd0);
    end

    // Hard reset restores a new game
    step(1, 0, 0, 0, 0, 6'd0);
    chk("hard_lives", int'(lives), 3);
    chk("hard_level", int'(level), 0);
    chk("hard_done", int'(ih_isdone), 0);

    // Idle timeout after 20 capturing cycles
    step(0, 0, 1, 0, 0, 6'd0);
    repeat (19) step(0, 0, 0, 0, 0, 6'd0);
    chk("to_not_yet", int'(ih_isdone), 0);
    step(0, 0, 0, 0, 0, 6'd0);
    chk("to_done", int'(ih_isdone), 1);
    repeat (3) step(0, 0, 0, 0, 0, 6'd0);
    chk("to_hold", int'(ih_isdone), 1);
    step(0, 0, 0, 1, 0, 6'd0);
    chk("to_win", int'(win), 0);
    chk("to_lives", int'(lives), 2);
    step(0, 1, 0, 0, 0, 6'd0);

    // Held key counts once; a chord is a miss
    step(0, 0, 1, 0, 0, 6'd0);
    repeat (10) step(0, 0, 0, 0, 0, 6'h01);
    chk("hold_idx", int'(note_index), 1);
    step(0, 0, 0, 0, 0, 6'h00);
    step(0, 0, 0, 0, 0, 6'h05);
    chk("chord_idx", int'(note_index), 2);
    step(0, 0, 0, 0, 0, 6'h00);
    step(0, 0, 0, 0, 0, 6'h10);
    chk("chord_done", int'(ih_isdone), 1);
    step(0, 0, 0, 1, 0, 6'd0);
    chk("chord_win", int'(win), 0);
    chk("chord_lives", int'(lives), 1);

    // Level advance with auto_reset and next_level together
    step(1, 0, 0, 0, 0, 6'd0);
    for (int lv = 0; lv < 3; lv++) begin
      play(lv, -1);
      step(0, 0, 0, 1, 0, 6'd0);
      chk("adv_win", int'(win), 1);
      chk("adv_lives", int'(lives), 3);
      step(0, 1, 0, 0, 1, 6'd0);
      chk("adv_level", int'(level), lv + 1);
      chk("adv_lives_after", int'(lives), 3);
      chk("adv_win_after", int'(win), 0);
      chk("adv_exp", int'(expected_note), 1 << seq_tab[lv + 1][0]);
    end
    play(3, 4);
    step(0, 0, 0, 1, 0, 6'd0);
    chk("l3_lives", int'(lives), 2);
    step(0, 1, 0, 0, 1, 6'd0);
    chk("l3_level_sat", int'(level), 3);
    chk("l3_lives_restored", int'(lives), 3);
    chk("l3_exp", int'(expected_note), 'h04);

    // Asynchronous reset mid-round
    step(1, 0, 0, 0, 0, 6'd0);
    step(0, 0, 1, 0, 0, 6'd0);
    step(0, 0, 0, 0, 0, 6'h01);
    step(0, 0, 0, 0, 0, 6'h00);
    step(0, 0, 0, 0, 0, 6'h04);
    chk("ar_pre_idx", int'(note_index), 2);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_idx", int'(note_index), 0);
    chk("ar_exp", int'(expected_note), 1);
    chk("ar_done", int'(ih_isdone), 0);
    @(negedge clock);
    resetn = 1'b1;
    step(0, 0, 0, 1, 0, 6'd0);
    chk("ar_chk_lives", int'(lives), 3);
    chk("ar_chk_win", int'(win), 0);
    chk("ar_chk_done", int'(ih_isdone), 0);

    // Randomized run against the reference model
    step(1, 0, 0, 0, 0, 6'd0);
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      r_hr = ($urandom_range(0, 299) == 0);
      r_ar = ($urandom_range(0, 24) == 0);
      r_nl = ($urandom_range(0, 59) == 0);
      r_l1 = ($urandom_range(0, 5) == 0);
      r_ck = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 7);
      if (r < 4) r_ui = 6'd0;
      else if (r < 6) begin
        r_ui = m_expected();
        if (r_ui == 6'd0) r_ui = 6'h01;
      end else if (r == 6) r_ui = 6'd1 << $urandom_range(0, 5);
      else r_ui = 6'($urandom_range(0, 63));
      step(r_hr, r_ar, r_l1, r_ck, r_nl, r_ui);
      model_step(r_hr, r_ar, r_l1, r_ck, r_nl, r_ui);
      chk("rnd_done", int'(ih_isdone), int'(m_done));
      chk("rnd_win", int'(win), int'(m_win));
      chk("rnd_lives", int'(lives), m_lives);
      chk("rnd_level", int'(level), m_level);
      chk("rnd_idx", int'(note_index), m_idx);
      if (m_idx < m_level + 3) chk("rnd_exp", int'(expected_note), int'(m_expected()));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sequence_scorer.md
SEQUENCE_SCORER -- requirements
Module: sequence_scorer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 250000000, giving the maximum idle cycles between presses before the round is aborted.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port hard_reset, input, 1 bit: synchronous new-game clear.
REQ-005 SHALL have port auto_reset, input, 1 bit: synchronous round clear.
REQ-006 SHALL have port level_one_active, input, 1 bit: one-cycle pulse that arms capture.
REQ-007 SHALL have port check_score_enable, input, 1 bit: one-cycle pulse that evaluates the round.
REQ-008 SHALL have port next_level, input, 1 bit: one-cycle pulse that advances the level.
REQ-009 SHALL have port user_input, input, 6 bits: piano key lines, active-high.
REQ-010 SHALL have port ih_isdone, output, 1 bit: the round is finished.
REQ-011 SHALL have port win, output, 1 bit: the last evaluated round had no miss.
REQ-012 SHALL have port lives, output, 2 bits: remaining lives.
REQ-013 SHALL have port level, output, 2 bits: current level.
REQ-014 SHALL have port expected_note, output, 6 bits: one-hot note expected at note_index, for the tone player.
REQ-015 SHALL have port note_index, output, 3 bits: position within the sequence.

Function
REQ-016 SHALL fix the sequence length at L = level+3 notes; notes are numbered 0..5, and note n maps to user_input bit n.
REQ-017 SHALL use these sequences: level 0 = 0,2,4; level 1 = 1,3,5,3; level 2 = 5,4,2,0,1; level 3 = 2,0,3,5,1,4.
REQ-018 SHALL drive expected_note combinationally as the one-hot encoding of seq[level][note_index].
REQ-019 SHALL implement the states IDLE, ARMED and DONE.
REQ-020 SHALL move from IDLE to ARMED on level_one_active, and SHALL ignore level_one_active in ARMED and DONE.
REQ-021 SHALL, in ARMED, register user_input each cycle; a press is user_input != 0 while the previous sample was 0.
REQ-022 SHALL, on a press, compare the pressed value with expected_note; any inequality, including multiple bits set, sets the internal miss flag.
REQ-023 SHALL, on each press, increment note_index and clear the idle counter.
REQ-024 SHALL, on the press where note_index equals L-1, move to DONE and set ih_isdone the next cycle (1-cycle latency).
REQ-025 SHALL increment the idle counter each ARMED cycle without a press.
REQ-026 SHALL, when the idle counter reaches TIMEOUT_CYCLES-1, set miss, move to DONE and set ih_isdone.
REQ-027 SHALL ignore presses in IDLE and DONE.
REQ-028 SHALL hold ih_isdone at 1 in DONE until auto_reset or hard_reset.
REQ-029 SHALL, on check_score_enable in DONE, set win = ~miss.
REQ-030 SHALL, on check_score_enable in DONE with miss set, decrement lives, saturating at 0.
REQ-031 SHALL ignore check_score_enable outside DONE.
REQ-032 SHALL keep win registered until auto_reset, next_level or hard_reset.
REQ-033 SHALL, on auto_reset, go to IDLE and clear note_index, the idle counter, miss, ih_isdone and win; lives and level are kept.
REQ-034 SHALL, on next_level, increment level (saturating at 3), restore lives to 3, clear win, clear note_index and go to IDLE.
REQ-035 SHALL, on hard_reset, load level=0, lives=3, win=0, ih_isdone=0, note_index=0, miss=0 and state IDLE.
REQ-036 SHALL resolve simultaneous controls in priority order: hard_reset > (auto_reset and next_level, both applied together) > check_score_enable > level_one_active > press/timeout.
REQ-037 SHALL, on a press and a timeout in the same cycle, take the press.

Reset
REQ-038 SHALL, while resetn=0, asynchronously force IDLE with ih_isdone=0, win=0, lives=3, level=0, note_index=0, miss=0, idle counter=0 and sampled input=0, so that expected_note=6'b000001.
REQ-039 SHALL abandon any round in progress when resetn is asserted mid-round, with no further lives change.

Verification (TIMEOUT_CYCLES=20)
REQ-040 Level 0: pulse level_one_active, then press 000001, 000100, 010000 with releases between -> ih_isdone=1 one cycle after the third press; check_score_enable -> win=1, lives=3.
REQ-041 Level 0: second press 001000 -> after three presses ih_isdone=1; check_score_enable -> win=0, lives=2; three such rounds -> lives=0, and a fourth stays 0.
REQ-042 Arm and press nothing for 20 cycles -> ih_isdone=1; check_score_enable -> win=0, lives decremented.
REQ-043 Hold 000001 for 10 cycles -> counts as one press, note_index=1; pressing 000101 -> miss.
REQ-044 auto_reset and next_level in the same cycle as win=1 -> level=1, lives=3, win=0, expected_note=000010; repeating to level 3 then once more -> level stays 3.
REQ-045 resetn low mid-round (note_index=2) -> immediately IDLE, note_index=0; check_score_enable after release -> no change.
